// File: rtl/sm_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// The digit registers for the three-digit display change only when a conversion completes.
module sm_bin2bcd_seq #(
  parameter int         WIDTH     = 10,
  parameter logic [3:0] OVF_DIGIT = 4'hE
) (
  input  logic             clkIn,
  input  logic             rstIn,
  input  logic [WIDTH-1:0] bin_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       digit_out_1,
  output logic [3:0]       digit_out_2,
  output logic [3:0]       digit_out_3,
  output logic             ovf,
  output logic             done
);

  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
  localparam int              WW   = WIDTH + 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t          state_r;
  logic [WW-1:0]   work_r;
  logic [CW-1:0]   cnt_r;
  logic            ovf_pend_r;

  // 4-bit add-3 correction; any wrap stays inside the nibble
  function automatic logic [3:0] add3(input logic [3:0] nib);
    if (nib >= 4'd5) begin
      add3 = nib + 4'd3;
    end else begin
      add3 = nib;
    end
  endfunction

  function automatic logic [WW-1:0] dabble_step(input logic [WW-1:0] w);
    logic [WW-1:0] a;
    a = w;
    a[WIDTH+11:WIDTH+8] = add3(w[WIDTH+11:WIDTH+8]);
    a[WIDTH+7:WIDTH+4]  = add3(w[WIDTH+7:WIDTH+4]);
    a[WIDTH+3:WIDTH]    = add3(w[WIDTH+3:WIDTH]);
    dabble_step = {a[WW-2:0], 1'b0};
  endfunction

  // Converter FSM with registered handshake, digits, overflow and done pulse
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_r     <= IDLE;
      work_r      <= '0;
      cnt_r       <= '0;
      ovf_pend_r  <= 1'b0;
      in_ready    <= 1'b1;
      digit_out_1 <= 4'd0;
      digit_out_2 <= 4'd0;
      digit_out_3 <= 4'd0;
      ovf         <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            work_r     <= {12'd0, bin_in};
            cnt_r      <= '0;
            // zero-extension makes this constant-false when WIDTH < 10
            ovf_pend_r <= (10'(bin_in) > 10'd999);
            in_ready   <= 1'b0;
            state_r    <= SHIFT;
          end else begin
            in_ready <= 1'b1;
            state_r  <= IDLE;
          end
        end
        SHIFT: begin
          work_r   <= dabble_step(work_r);
          cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          in_ready <= 1'b0;
          if (cnt_r == LAST) begin
            state_r <= LOAD;
          end else begin
            state_r <= SHIFT;
          end
        end
        LOAD: begin
          if (ovf_pend_r) begin
            digit_out_1 <= OVF_DIGIT;
            digit_out_2 <= OVF_DIGIT;
            digit_out_3 <= OVF_DIGIT;
            ovf         <= 1'b1;
          end else begin
            digit_out_1 <= work_r[WIDTH+3:WIDTH];
            digit_out_2 <= work_r[WIDTH+7:WIDTH+4];
            digit_out_3 <= work_r[WIDTH+11:WIDTH+8];
            ovf         <= 1'b0;
          end
          done     <= 1'b1;
          in_ready <= 1'b1;
          state_r  <= IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_bin2bcd_seq.sv
// Directed bench for sm_bin2bcd_seq (WIDTH=10): reset, latency, boundaries,
// overflow, busy-ignore, back-to-back and output hold.
module tb_sm_bin2bcd_seq;

  logic       clk;
  logic       rst;
  logic [9:0] bin_in;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] d1, d2, d3;
  logic       ovf;
  logic       done;

  int total = 0;
  int bad   = 0;

  sm_bin2bcd_seq #(.WIDTH(10), .OVF_DIGIT(4'hE)) dut (
    .clkIn(clk), .rstIn(rst), .bin_in(bin_in), .in_valid(in_valid),
    .in_ready(in_ready), .digit_out_1(d1), .digit_out_2(d2),
    .digit_out_3(d3), .ovf(ovf), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_digits(input string tag, input logic [3:0] e3, input logic [3:0] e2,
                              input logic [3:0] e1, input logic eo);
    check({tag, " digits"}, {20'd0, d3, d2, d1}, {20'd0, e3, e2, e1});
    check({tag, " ovf"}, {31'd0, ovf}, {31'd0, eo});
  endtask

  // Samples #1 after each edge until done; counts busy (in_ready=0) samples
  task automatic wait_done(output int n, output int lows);
    n = 0;
    lows = 0;
    while (!done && n < 40) begin
      if (!in_ready) lows++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic convert(input string tag, input logic [9:0] v, input logic [3:0] e3,
                         input logic [3:0] e2, input logic [3:0] e1, input logic eo);
    int n, lows;
    check({tag, " ready before"}, {31'd0, in_ready}, 32'd1);
    bin_in = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    bin_in = ~v;
    wait_done(n, lows);
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " latency"}, n, 32'd11);
    check({tag, " busy cycles"}, lows, 32'd11);
    check({tag, " ready at done"}, {31'd0, in_ready}, 32'd1);
    check_digits(tag, e3, e2, e1, eo);
    @(posedge clk); #1;
    check({tag, " done pulse width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n, lows, seen;
    logic [3:0] h1, h2, h3;
    logic       ho;

    rst = 1'b1;
    in_valid = 1'b0;
    bin_in = 10'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_digits("reset", 4'd0, 4'd0, 4'd0, 1'b0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset ready", {31'd0, in_ready}, 32'd1);

    // reset in the middle of converting 123
    bin_in = 10'd123;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("abort busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (15) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    check("abort no done", seen, 32'd0);
    check_digits("abort", 4'd0, 4'd0, 4'd0, 1'b0);

    convert("v255", 10'd255, 4'd2, 4'd5, 4'd5, 1'b0);

    // outputs hold across idle cycles with a noisy bin_in
    seen = 0;
    h1 = d1; h2 = d2; h3 = d3; ho = ovf;
    repeat (50) begin
      bin_in = 10'($urandom);
      @(posedge clk); #1;
      if (done || d1 !== h1 || d2 !== h2 || d3 !== h3 || ovf !== ho) seen++;
    end
    check("hold changes", seen, 32'd0);
    check_digits("hold", 4'd2, 4'd5, 4'd5, 1'b0);

    convert("v0",   10'd0,   4'd0, 4'd0, 4'd0, 1'b0);
    convert("v9",   10'd9,   4'd0, 4'd0, 4'd9, 1'b0);
    convert("v10",  10'd10,  4'd0, 4'd1, 4'd0, 1'b0);
    convert("v99",  10'd99,  4'd0, 4'd9, 4'd9, 1'b0);
    convert("v100", 10'd100, 4'd1, 4'd0, 4'd0, 1'b0);
    convert("v999", 10'd999, 4'd9, 4'd9, 4'd9, 1'b0);
    convert("v1000", 10'd1000, 4'hE, 4'hE, 4'hE, 1'b1);
    convert("v1023", 10'd1023, 4'hE, 4'hE, 4'hE, 1'b1);
    convert("v42",  10'd42,  4'd0, 4'd4, 4'd2, 1'b0);

    // a request while busy is ignored, not queued
    bin_in = 10'd77;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    bin_in = 10'd500;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    bin_in = 10'd0;
    wait_done(n, lows);
    check("busy77 latency", n, 32'd7);
    check_digits("busy77", 4'd0, 4'd7, 4'd7, 1'b0);
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("busy500 not queued", seen, 32'd0);
    check_digits("busy after", 4'd0, 4'd7, 4'd7, 1'b0);

    // back-to-back with in_valid held high
    bin_in = 10'd5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    wait_done(n, lows);
    check("b2b first latency", n, 32'd11);
    check_digits("b2b first", 4'd0, 4'd0, 4'd5, 1'b0);
    bin_in = 10'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b accepted", {31'd0, in_ready}, 32'd0);
    wait_done(n, lows);
    check("b2b second latency", n, 32'd11);
    check_digits("b2b second", 4'd0, 4'd0, 4'd6, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
